// File: rtl/uart_pkg.sv
// Shared frame constants and state encodings for the UART transmitter and receiver.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a combinational read port; pushes when full and pops when empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART: queued transmitter and mid-bit sampling receiver with a valid/ready output,
// frame-error and overrun pulses. TX and RX are fully independent.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic [7:0] tx_tdata,
  input  logic       tx_tvalid,
  output logic       tx_tready,
  output logic [7:0] rx_tdata,
  output logic       rx_tvalid,
  input  logic       rx_tready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       uart_tx,
  input  logic       uart_rx
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic       w_fifo_full, w_fifo_empty, w_tx_pop, w_tx_tick;
  logic [7:0] w_fifo_dat;
  tx_state_t  r_tx_state, w_tx_next;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;
  logic       r_tx_out;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (tx_tvalid),
    .i_dat   (tx_tdata),
    .o_full  (w_fifo_full),
    .i_pop   (w_tx_pop),
    .o_dat   (w_fifo_dat),
    .o_empty (w_fifo_empty)
  );

  assign tx_tready = !w_fifo_full;
  assign uart_tx   = r_tx_out;

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    w_tx_tick = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: if (tx_en && !w_fifo_empty) begin
        w_tx_pop  = 1'b1;
        w_tx_next = TX_START;
      end
      TX_START: if (r_tx_cnt == BIT_LAST) begin
        w_tx_tick = 1'b1;
        w_tx_next = TX_DATA;
      end
      TX_DATA: if (r_tx_cnt == BIT_LAST) begin
        w_tx_tick = 1'b1;
        if (r_tx_bit == LAST_BIT) w_tx_next = TX_STOP;
      end
      TX_STOP: if (r_tx_cnt == STOP_LAST) begin
        w_tx_tick = 1'b1;
        // Chain straight into the next start bit when more data is waiting.
        if (tx_en && !w_fifo_empty) begin
          w_tx_pop  = 1'b1;
          w_tx_next = TX_START;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= (w_tx_tick || r_tx_state == TX_IDLE) ? '0 : r_tx_cnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_fifo_dat;
        r_tx_bit   <= '0;
        r_tx_out   <= 1'b0;
      end else if (w_tx_tick) begin
        case (r_tx_state)
          TX_START: r_tx_out <= r_tx_shift[0];
          TX_DATA: begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 1'b1;
            r_tx_out   <= (r_tx_bit == LAST_BIT) ? 1'b1 : r_tx_shift[1];
          end
          default: r_tx_out <= 1'b1;
        endcase
      end
    end
  end

  logic [1:0] r_rx_sync;
  logic       r_rx_prev, w_rx_line, w_rx_fall, w_rx_tick, w_rx_done, w_rx_ferr;
  rx_state_t  r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift, r_rx_dat;
  logic       r_rx_vld, r_rx_ferr, r_rx_ovr;

  assign w_rx_line    = r_rx_sync[1];
  // Requiring a high-to-low edge also keeps a line stuck low from re-arming after a frame error.
  assign w_rx_fall    = r_rx_prev && !w_rx_line;
  assign rx_tdata     = r_rx_dat;
  assign rx_tvalid    = r_rx_vld;
  assign rx_frame_err = r_rx_ferr;
  assign rx_overrun   = r_rx_ovr;

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_tick = 1'b0;
    w_rx_done = 1'b0;
    w_rx_ferr = 1'b0;
    if (!rx_en) begin
      w_rx_next = RX_IDLE;
    end else begin
      unique case (r_rx_state)
        RX_IDLE: if (w_rx_fall) w_rx_next = RX_START;
        RX_START: if (r_rx_cnt == HALF_LAST) begin
          w_rx_tick = 1'b1;
          w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (r_rx_cnt == BIT_LAST) begin
          w_rx_tick = 1'b1;
          if (r_rx_bit == LAST_BIT) w_rx_next = RX_STOP;
        end
        RX_STOP: if (r_rx_cnt == BIT_LAST) begin
          w_rx_tick = 1'b1;
          w_rx_next = RX_IDLE;
          w_rx_done = w_rx_line;
          w_rx_ferr = !w_rx_line;
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_dat   <= '0;
      r_rx_vld   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_rx};
      r_rx_prev  <= w_rx_line;
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= (w_rx_tick || !rx_en || r_rx_state == RX_IDLE) ? '0 : r_rx_cnt + 1'b1;
      if (w_rx_tick && r_rx_state == RX_START) r_rx_bit <= '0;
      if (w_rx_tick && r_rx_state == RX_DATA) begin
        r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      r_rx_ferr <= w_rx_ferr;
      r_rx_ovr  <= w_rx_done && r_rx_vld && !rx_tready;
      if (w_rx_done && (!r_rx_vld || rx_tready)) begin
        r_rx_dat <= r_rx_shift;
        r_rx_vld <= 1'b1;
      end else if (rx_tready) begin
        r_rx_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver at a short bit time (16 clocks) to keep runs brief.
module tb_uart_transceiver;
  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0, rx_en = 1'b0;
  logic [7:0] tx_tdata = '0;
  logic       tx_tvalid = 1'b0;
  logic       tx_tready;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready = 1'b1;
  logic       rx_frame_err, rx_overrun, uart_tx;
  logic       loop = 1'b1, rx_drv = 1'b1;
  logic       uart_rx_w;

  assign uart_rx_w = loop ? uart_tx : rx_drv;

  uart_transceiver #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .TX_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .rx_en(rx_en),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .uart_tx(uart_tx), .uart_rx(uart_rx_w)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, rx_count = 0, ferr_cnt = 0, ovr_cnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Scoreboard consumer: every RX handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_err) ferr_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_tvalid && rx_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got 0x%0h expected no byte", rx_tdata);
        end else begin
          check("rx_byte", {24'h0, rx_tdata}, {24'h0, exp_q.pop_front()});
        end
        rx_count++;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] d, input bit expect_rx, output int waited);
    waited = 0;
    tx_tdata  = d;
    tx_tvalid = 1'b1;
    while (tx_tready !== 1'b1 && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (tx_tready !== 1'b1) begin
      check("push_timeout", {31'h0, tx_tready}, 32'h1);
    end else begin
      @(posedge clk);
      if (expect_rx) exp_q.push_back(d);
      @(negedge clk);
    end
    tx_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, rx_count, target);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop, input int abort_at);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (b == abort_at) rx_en = 1'b0;
      rx_drv = f[b];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic count_idle(input int ncyc, output int high);
    high = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (uart_tx === 1'b1) high++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int lat, n, good, base, t0, fbase, obase, high;
    vecs[0] = '{8'h55, 10'h2AA};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'hA3, 10'h346};

    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_tx_tready", {31'h0, tx_tready}, 32'h1);
    check("rst_rx_tvalid", {31'h0, rx_tvalid}, 32'h0);
    check("rst_rx_tdata", {24'h0, rx_tdata}, 32'h0);
    check("rst_frame_err", {31'h0, rx_frame_err}, 32'h0);
    check("rst_overrun", {31'h0, rx_overrun}, 32'h0);
    rst = 1'b0;
    tx_en = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // Table: each byte's serial waveform, level by level, plus loopback delivery.
    for (int i = 0; i < 4; i++) begin
      push_byte(vecs[i].data, 1'b1, lat);
      n = 0;
      while (uart_tx !== 1'b0 && n < 8) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("tx_start_lat_v%0d", i), {31'h0, n <= 2}, 32'h1);
      for (int b = 0; b < 10; b++) begin
        good = 0;
        for (int c = 0; c < CPB; c++) begin
          if (uart_tx === vecs[i].frame[b]) good++;
          @(negedge clk);
        end
        check($sformatf("tx_level_v%0d_b%0d", i, b), good, CPB);
      end
      check($sformatf("tx_idle_after_v%0d", i), {31'h0, uart_tx}, 32'h1);
      repeat (4) @(negedge clk);
    end
    check("tbl_rx_count", rx_count, 4);

    // Back-to-back loopback with a completion deadline.
    base = rx_count;
    t0 = cyc;
    for (int i = 0; i < 4; i++) push_byte(8'h08 + 8'(i), 1'b1, lat);
    n = 0;
    while (rx_count < base + 4 && (cyc - t0) < 4 * FRAME + 10) @(negedge clk);
    check("lb_deadline", rx_count, base + 4);
    repeat (CPB) @(negedge clk);

    // Backpressure with the transmitter disabled.
    tx_en = 1'b0;
    base = rx_count;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h31 + 8'(i), 1'b1, lat);
      if (i == 2) check("bp_tready_3", {31'h0, tx_tready}, 32'h1);
    end
    check("bp_tready_full", {31'h0, tx_tready}, 32'h0);
    tx_tdata = 8'h35;
    tx_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_tready_hold", {31'h0, tx_tready}, 32'h0);
    check("bp_no_tx", {31'h0, uart_tx}, 32'h1);
    tx_en = 1'b1;
    push_byte(8'h35, 1'b1, lat);
    check("bp_5th_lat", {31'h0, lat <= 3}, 32'h1);
    wait_rx(base + 5, 5 * FRAME + 20, "bp_rx_count");
    repeat (CPB) @(negedge clk);

    // Pause mid-frame: the frame in flight finishes, the rest wait for re-enable.
    base = rx_count;
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i), 1'b1, lat);
    repeat (15 * CPB - 4) @(negedge clk);
    tx_en = 1'b0;
    wait_rx(base + 2, 2 * FRAME, "ss_two_done");
    repeat (CPB) @(negedge clk);
    count_idle(3 * FRAME, high);
    check("ss_idle_high", high, 3 * FRAME);
    check("ss_held_count", rx_count, base + 2);
    tx_en = 1'b1;
    wait_rx(base + 4, 2 * FRAME + 20, "ss_resume");
    repeat (CPB) @(negedge clk);

    // Receiver corner cases driven directly onto the line.
    tx_en = 1'b0;
    loop = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    base = rx_count;
    fbase = ferr_cnt;
    drive_frame(8'h5A, 1'b0, -1);
    repeat (CPB) @(negedge clk);
    check("ferr_pulse", ferr_cnt, fbase + 1);
    check("ferr_no_valid", {31'h0, rx_tvalid}, 32'h0);
    check("ferr_no_byte", rx_count, base);

    exp_q.push_back(8'h96);
    drive_frame(8'h96, 1'b1, -1);
    repeat (CPB) @(negedge clk);
    check("rx_after_ferr", rx_count, base + 1);

    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("false_start", rx_count, base + 1);
    check("false_start_ferr", ferr_cnt, fbase + 1);

    drive_frame(8'h77, 1'b1, 4);
    rx_en = 1'b1;
    repeat (CPB) @(negedge clk);
    check("abandon_no_byte", rx_count, base + 1);
    check("abandon_no_ferr", ferr_cnt, fbase + 1);
    exp_q.push_back(8'h69);
    drive_frame(8'h69, 1'b1, -1);
    repeat (CPB) @(negedge clk);
    check("rx_after_abandon", rx_count, base + 2);

    base = rx_count;
    obase = ovr_cnt;
    rx_tready = 1'b0;
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1, -1);
    drive_frame(8'hC3, 1'b1, -1);
    repeat (CPB) @(negedge clk);
    check("ovr_valid_held", {31'h0, rx_tvalid}, 32'h1);
    check("ovr_data_held", {24'h0, rx_tdata}, 32'h3C);
    check("ovr_pulse_once", ovr_cnt, obase + 1);
    rx_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_drain", rx_count, base + 1);
    check("ovr_valid_clear", {31'h0, rx_tvalid}, 32'h0);

    // Reset in mid-frame with a full queue behind it.
    loop = 1'b1;
    tx_en = 1'b1;
    base = rx_count;
    fbase = ferr_cnt;
    push_byte(8'hA5, 1'b0, lat);
    for (int i = 0; i < 4; i++) push_byte(8'h11 * 8'(i + 1), 1'b0, lat);
    check("mr_full_before", {31'h0, tx_tready}, 32'h0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("mr_tx_tready", {31'h0, tx_tready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    count_idle(2 * FRAME, high);
    check("mr_idle_after", high, 2 * FRAME);
    check("mr_no_byte", rx_count, base);
    check("mr_no_ferr", ferr_cnt, fbase);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
